tt_sweep_checker: RTL
=====================

# tt_sweep_checker

Self-running stimulus and check stage for the lab's 4-input combinational functions. On `start` it drives all 16 input combinations (a,b,c,d) into the function under test in ascending order. It samples the single-bit output `f` for each vector and compares it against a 16-bit expected truth table. It then reports pass/fail, error count, a per-vector fail mask and the first failing vector. It sits directly upstream of the combinational block, which it feeds, and downstream of it, since it consumes that block's `f`.

## Interface
Parameters:
- `HOLD`, default 2: clock cycles each vector is held before `f` is sampled; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a sweep; honoured only when not busy.
- `exp_mask`  in  16  expected truth table; bit i is expected `f` for vector i = {a,b,c,d} (a = MSB); latched on the accepted start edge.
- `f`  in  1  output of the function under test.
- `a`, `b`, `c`, `d`  out  1 each  vector bits to the function under test; {a,b,c,d} = current index.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse after the last vector is checked.
- `pass`  out  1  1 when the last completed sweep had zero mismatches.
- `err_count`  out  5  mismatches in the current or last sweep, range 0..16.
- `fail_mask`  out  16  bit i set if vector i mismatched.
- `first_fail`  out  4  lowest failing vector index.
- `first_fail_valid`  out  1  `first_fail` holds a valid index.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - {a,b,c,d} = 0000 and `busy` = 0.
  - `start` = 1 at an edge → RUN. On that edge: latch `exp_mask`, set idx = 0, hold_cnt = 0, clear `err_count`, `fail_mask`, `pass`, `first_fail` and `first_fail_valid`.
- **RUN:**
  - `busy` = 1 and {a,b,c,d} = idx.
  - hold_cnt increments each edge.
  - At the edge where hold_cnt == HOLD-1, sample `f` and compare with latched mask[idx]:
    - On mismatch: `err_count` += 1 and `fail_mask`[idx] = 1.
    - If `first_fail_valid` = 0: `first_fail` = idx and `first_fail_valid` = 1.
  - On the same edge, hold_cnt resets to 0 and idx increments.
  - When the sampled vector was idx = 15, go to DONE instead. `pass` is set to (final error count == 0), including the mismatch from vector 15 itself.
- **DONE:**
  - Lasts exactly one cycle, with `done` = 1, `busy` = 0 and {a,b,c,d} = 0000.
  - Next state is IDLE, or RUN if `start` = 1 on that edge (back-to-back sweep with results cleared as above).
- **Arithmetic:** idx is a 4-bit register; `err_count` is 5 bits and must reach 16 without wrap.
- **Start while busy:** `start` asserted during RUN is ignored; there is no queuing.
- **Result retention:** results hold their values from DONE until the next accepted start.
- **Reset:** `rst_n` low at any time, including mid-sweep, immediately forces IDLE. All outputs go to 0, {a,b,c,d} = 0000, and the latched mask and counters clear. The sweep does not resume after reset deasserts.

## Timing
- **Accepted start at edge E0:**
  - `busy` rises and vector 0 is driven after E0.
  - Vector i is driven from E0 + i·HOLD to E0 + (i+1)·HOLD.
  - Vector i is sampled at edge E0 + (i+1)·HOLD.
- **Final sample:** occurs at E0 + 16·HOLD. `busy` falls and `done`, `pass` and the final results become visible after that edge. `done` falls at E0 + 16·HOLD + 1.
- **Latency:** start edge to done rise is 16·HOLD cycles, i.e. 32 cycles for HOLD=2 and 16 cycles for HOLD=1.
- **`f` settling:** `f` is treated as combinational from {a,b,c,d}. The `f` settling time available is HOLD cycles minus the registered-output delay.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** assert `rst_n` = 0 with random inputs → all outputs 0 and {a,b,c,d} = 0000. Release reset with `start` = 0 → outputs remain 0.
- **Correct DUT:** HOLD=2, bench models f = exp_mask[{a,b,c,d}], mask 16'hA5C3, start at E0 → vectors step 0..15 every 2 cycles and `done` at E0+32. Results: `pass` = 1, `err_count` = 0, `fail_mask` = 0, `first_fail_valid` = 0.
- **Stuck-at-0:** f tied to 0, mask 16'h0101 → `err_count` = 2, `fail_mask` = 16'h0101, `first_fail` = 0, `first_fail_valid` = 1, `pass` = 0.
- **Single fault / full fault:**
  - Model correct except at vector 13, mask 16'h0000 → `err_count` = 1, `fail_mask` = 16'h2000, `first_fail` = 13.
  - f = ~expected → `err_count` = 16 (5'b10000) and `fail_mask` = 16'hFFFF.
- **Start while busy, then reset mid-sweep:**
  - Pulse `start` at vector 5 → no effect, and `done` still arrives at E0+32.
  - New sweep, drop `rst_n` while vector 7 is driven → `busy` = 0 and {a,b,c,d} = 0000 immediately. No `done` ever appears; the next start runs a clean full sweep.
- **Back-to-back, HOLD=1:** hold `start` high continuously with HOLD=1 → `done` after 16 cycles, the new sweep starts on the DONE edge, and results clear. Second `done` exactly 17 cycles after the first.

Source files
------------

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker
//   Self-running exhaustive checker for a 4-input combinational function.
//   On an accepted start it walks {a,b,c,d} through 0..15. Each vector is held
//   for HOLD cycles, and then the function output f is compared against the
//   latched expected truth table. Once all 16 vectors are done it reports
//   pass/fail, the error count, a per-vector fail mask and the first failing
//   vector.
//
// Ports
//   clk              : single clock, rising edge
//   rst_n            : asynchronous active-low reset
//   start            : request a sweep (ignored while a sweep is running)
//   exp_mask[15:0]   : expected truth table, bit i = f for vector i
//   f                : output of the function under test
//   a,b,c,d          : vector to the function under test, {a,b,c,d} = index
//   busy             : sweep in progress
//   done             : one-cycle pulse after the last vector is checked
//   pass             : last completed sweep had no mismatches
//   err_count[4:0]   : mismatch count, 0..16
//   fail_mask[15:0]  : bit i set if vector i mismatched
//   first_fail[3:0]  : lowest failing vector index
//   first_fail_valid : first_fail holds a valid index
module tt_sweep_checker #(
   parameter int HOLD = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] exp_mask,
   input  logic        f,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  err_count,
   output logic [15:0] fail_mask,
   output logic [3:0]  first_fail,
   output logic        first_fail_valid
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [3:0]  r_idx;
   logic [3:0]  r_hold;
   logic [15:0] r_mask;
   logic        r_busy;
   logic        r_done;
   logic        r_pass;
   logic [4:0]  r_err;
   logic [15:0] r_fail_mask;
   logic [3:0]  r_first_fail;
   logic        r_ffv;

   logic        w_accept;
   logic        w_sample;
   logic        w_miss;
   logic        w_last;
   logic [4:0]  w_err_next;

   // A new sweep may begin from IDLE or directly from the DONE cycle.
   assign w_accept   = start && (r_state != S_RUN);
   assign w_sample   = (r_state == S_RUN) && (r_hold == 4'(HOLD - 1));
   assign w_miss     = f ^ r_mask[r_idx];
   assign w_last     = (r_idx == 4'd15);
   // 5-bit sum so that 16 mismatches do not wrap.
   assign w_err_next = r_err + {4'd0, w_miss};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_idx        <= 4'd0;
         r_hold       <= 4'd0;
         r_mask       <= 16'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err        <= 5'd0;
         r_fail_mask  <= 16'd0;
         r_first_fail <= 4'd0;
         r_ffv        <= 1'b0;
      end else begin
         r_done <= w_sample && w_last;
         if (w_accept) begin
            r_state      <= S_RUN;
            r_busy       <= 1'b1;
            r_mask       <= exp_mask;
            r_idx        <= 4'd0;
            r_hold       <= 4'd0;
            r_pass       <= 1'b0;
            r_err        <= 5'd0;
            r_fail_mask  <= 16'd0;
            r_first_fail <= 4'd0;
            r_ffv        <= 1'b0;
         end else begin
            case (r_state)
               S_RUN: begin
                  if (w_sample) begin
                     r_hold <= 4'd0;
                     // Wraps 15 -> 0, so the vector outputs return to 0000
                     // on entry to DONE without extra logic.
                     r_idx  <= r_idx + 4'd1;
                     if (w_miss) begin
                        r_err              <= w_err_next;
                        r_fail_mask[r_idx] <= 1'b1;
                        if (!r_ffv) begin
                           r_first_fail <= r_idx;
                           r_ffv        <= 1'b1;
                        end
                     end
                     if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_pass  <= (w_err_next == 5'd0);
                     end
                  end else begin
                     r_hold <= r_hold + 4'd1;
                  end
               end
               S_DONE:  r_state <= S_IDLE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign {a, b, c, d}     = r_idx;
   assign busy             = r_busy;
   assign done             = r_done;
   assign pass             = r_pass;
   assign err_count        = r_err;
   assign fail_mask        = r_fail_mask;
   assign first_fail       = r_first_fail;
   assign first_fail_valid = r_ffv;

endmodule
